z16_fetch_unit: RTL and testbench
=================================

# z16_fetch_unit

Instruction fetch front-end for the Z16 core. Owns the fetch program counter, issues 16-bit instruction reads to instruction memory over a req/ack handshake, and buffers the returned words in a small prefetch FIFO. Presents instruction and PC to the decoder over a valid/ready handshake. Accepts a redirect (flush plus new PC) from the execute side for jumps and branches.

## Interface
Parameters:
- DEPTH, 4: prefetch FIFO entries; power of two, ≥ 2.
- RESET_PC, 16'h0000: fetch PC loaded at reset.

Ports:
- i_clk  in  1  single clock; all state updates on rising edge.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_redirect  in  1  flush FIFO and restart fetch at i_redirect_pc.
- i_redirect_pc  in  16  new fetch byte address.
- o_imem_req  out  1  read request.
- o_imem_addr  out  16  byte address of request; bit 0 always 0.
- i_imem_ack  in  1  memory accepts request and returns data this cycle.
- i_imem_data  in  16  instruction word, valid when o_imem_req && i_imem_ack.
- o_instr_valid  out  1  FIFO head valid.
- o_instr  out  16  FIFO head instruction.
- o_instr_pc  out  16  byte address of o_instr.
- i_instr_ready  in  1  decoder consumes head when o_instr_valid also high.
- o_fault  out  1  misaligned redirect fault (see Configuration).

## Operation
- FSM states: FETCH, FULL, FAULT.
  - FETCH: o_imem_req = !i_redirect. Go to FULL when count reaches DEPTH.
  - FULL: o_imem_req = 0. Return to FETCH when count < DEPTH.
  - FAULT: o_imem_req = 0 and o_instr_valid = 0. Exits only by reset.
- o_imem_req = (count < DEPTH) && !i_redirect && state != FAULT; combinational.
- o_imem_addr = r_fetch_pc.
- Memory transfer: o_imem_req && i_imem_ack.
  - Pushes {r_fetch_pc, i_imem_data} into the FIFO.
  - r_fetch_pc += 2, wraps 16'hFFFE → 16'h0000.
  - No outstanding transactions; i_imem_ack without o_imem_req is ignored.
- Decoder transfer: o_instr_valid && i_instr_ready pops the head.
- o_instr_valid = (count != 0).
- Push and pop in the same cycle leaves count unchanged. A push when count == DEPTH cannot occur, because req is gated off.
- Redirect takes priority over everything else in its cycle:
  - A decoder handshake in that cycle still counts as consumed.
  - All entries are then discarded: count ← 0, pointers ← 0.
  - r_fetch_pc ← i_redirect_pc, with bit 0 cleared.
  - FSM ← FETCH.
  - No memory transfer occurs in the redirect cycle.
- Reset (i_rst_n low at edge): r_fetch_pc ← RESET_PC, count and pointers ← 0, FSM ← FETCH, o_fault ← 0. While i_rst_n is low, o_imem_req and o_instr_valid are forced to 0. Reset mid-stream discards everything.

## Timing
- Reset release at edge E0 gives o_imem_req = 1 in cycle 1, with addr RESET_PC.
- Memory-to-decoder latency: a word acked in cycle N is at the FIFO head with o_instr_valid = 1 in cycle N+1 (when the FIFO was empty).
- Sustained throughput with ack and ready always high: 1 instruction/cycle.
- Redirect in cycle R: o_instr_valid = 0 in R+1; request for the new PC in R+1; first new instruction valid in R+2 at the earliest.
- o_instr and o_instr_pc hold stable while o_instr_valid && !i_instr_ready.

## Configuration
- Z16_FETCH_ALIGN_CHECK_EN defined:
  - A redirect with i_redirect_pc[0] = 1 flushes the FIFO, moves the FSM to FAULT, and sets o_fault = 1 from the next cycle.
  - o_fault is sticky until reset.
- Z16_FETCH_ALIGN_CHECK_EN undefined:
  - Bit 0 is silently cleared.
  - FAULT is unreachable and o_fault is tied to 0.

## Structure
- Package z16_pkg: Z16_XLEN = 16, Z16_INSTR_BYTES = 2, Z16_RESET_PC, and the fetch FSM state enum.
- Sub-module z16_fetch_fifo: parameterised sync FIFO.
  - Push, pop and flush inputs; count output; 32-bit entries {pc, instr}.
  - Flush beats push.
- z16_fetch_unit holds the PC, the FSM and the handshake glue.

## Test plan
- Reset, then ack and ready held high: addresses 0x0000, 0x0002, 0x0004…; decoder sees pc 0x0000 with its data in cycle 2, then one per cycle.
- i_instr_ready low, ack high: exactly DEPTH = 4 pushes (pcs 0x0000–0x0006), then req = 0; raise ready and the decoder receives 0x0000–0x0006 in order with no loss.
- Redirect to 0x0100 with 3 entries buffered and ready high that cycle: head consumed, rest dropped; next valid instr has pc 0x0100 within 2 cycles.
- Fetch PC 0xFFFE acked: next address 0x0000 (wrap).
- i_rst_n low for one cycle mid-stream with a full FIFO: o_instr_valid = 0 in the next cycle; fetch restarts at RESET_PC.
- Macro defined, redirect to 0x0101: o_fault = 1 next cycle, req stays 0, valid stays 0 until reset. Macro undefined: fetch from 0x0100, o_fault = 0.

Source files
------------

// File: rtl/z16_pkg.sv
// Shared Z16 definitions: datapath widths, reset PC, fetch FSM states and
// the prefetch FIFO entry layout.
package z16_pkg;

    localparam int          Z16_XLEN        = 16;
    localparam int          Z16_INSTR_BYTES = 2;
    localparam logic [15:0] Z16_RESET_PC    = 16'h0000;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_FULL  = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_t;

    // One prefetched instruction together with the byte address it came from.
    typedef struct packed {
        logic [Z16_XLEN-1:0] pc;
        logic [Z16_XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/z16_fetch_fifo.sv
// Synchronous prefetch FIFO for the Z16 fetch unit. Holds {pc, instr}
// entries. Flush (or reset) empties it and beats a simultaneous push.
// The head entry is presented combinationally from storage.
module z16_fetch_fifo
    import z16_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_push,
    input  fetch_entry_t  i_data,
    input  logic          i_pop,
    input  logic          i_flush,
    output fetch_entry_t  o_head,
    output logic [CW-1:0] o_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    // Overflow and underflow requests are dropped rather than corrupting state.
    assign do_push = i_push && (count != FULL_CNT) && !i_flush;
    assign do_pop  = i_pop  && (count != '0);

    // Entry storage; no reset needed since count gates visibility.
    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap since DEPTH is 2^n.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign o_head  = mem[rd_ptr];
    assign o_count = count;

endmodule

// File: rtl/z16_fetch_unit.sv
// Z16 instruction fetch front-end: owns the fetch PC, issues single-cycle
// req/ack reads to instruction memory, buffers words in a prefetch FIFO and
// hands {instr, pc} to the decoder over valid/ready. A redirect flushes the
// FIFO and restarts fetch at the new PC.
// Optional feature macro: Z16_FETCH_ALIGN_CHECK_EN -- when defined, a redirect
// to an odd address locks the unit in FAULT with o_fault set until reset;
// otherwise bit 0 of the redirect PC is silently cleared.
module z16_fetch_unit
    import z16_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [15:0] RESET_PC = Z16_RESET_PC
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_redirect,
    input  logic [15:0] i_redirect_pc,
    output logic        o_imem_req,
    output logic [15:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [15:0] i_imem_data,
    output logic        o_instr_valid,
    output logic [15:0] o_instr,
    output logic [15:0] o_instr_pc,
    input  logic        i_instr_ready,
    output logic        o_fault
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    fetch_state_t  state;
    logic          fault_q;
    logic [15:0]   fetch_pc;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          in_fault;
    logic          push;
    logic          pop;
    logic          bad_align;
    fetch_entry_t  head;
    fetch_entry_t  new_entry;

`ifdef Z16_FETCH_ALIGN_CHECK_EN
    assign bad_align = i_redirect && i_redirect_pc[0];
`else
    assign bad_align = 1'b0;
`endif

    assign in_fault = (state == ST_FAULT);

    // Reset low forces both handshakes idle regardless of stored state.
    assign o_imem_req    = i_rst_n && (count < FULL_CNT) && !i_redirect && !in_fault;
    assign o_imem_addr   = fetch_pc;
    assign o_instr_valid = i_rst_n && (count != '0) && !in_fault;

    assign push = o_imem_req && i_imem_ack;
    assign pop  = o_instr_valid && i_instr_ready;

    assign new_entry = '{pc: fetch_pc, instr: i_imem_data};

    // Occupancy after this edge, ignoring flush; used for FETCH/FULL tracking.
    always_comb begin
        count_next = count;
        if (push && !pop)      count_next = count + CW'(1);
        else if (pop && !push) count_next = count - CW'(1);
    end

    z16_fetch_fifo #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (push),
        .i_data  (new_entry),
        .i_pop   (pop),
        .i_flush (i_redirect),
        .o_head  (head),
        .o_count (count)
    );

    assign o_instr    = head.instr;
    assign o_instr_pc = head.pc;

    // Fetch PC: redirect wins, otherwise advance one instruction per transfer.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            fetch_pc <= RESET_PC;
        end else if (i_redirect) begin
            fetch_pc <= i_redirect_pc & ~16'h0001;
        end else if (push) begin
            fetch_pc <= fetch_pc + 16'(Z16_INSTR_BYTES);
        end
    end

    // Fetch FSM with registered fault flag; FAULT is left only by reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state   <= ST_FETCH;
            fault_q <= 1'b0;
        end else if (state != ST_FAULT) begin
            if (i_redirect) begin
                if (bad_align) begin
                    state   <= ST_FAULT;
                    fault_q <= 1'b1;
                end else begin
                    state <= ST_FETCH;
                end
            end else begin
                case (state)
                    ST_FETCH: if (count_next == FULL_CNT) state <= ST_FULL;
                    ST_FULL:  if (count_next <  FULL_CNT) state <= ST_FETCH;
                    default:  state <= ST_FETCH;
                endcase
            end
        end
    end

    assign o_fault = fault_q;

endmodule

// File: tb/tb_z16_fetch_unit.sv
// Self-checking bench for z16_fetch_unit: directed scenarios plus random
// traffic, all compared against a queue-based reference model.
// Build with +define+Z16_FETCH_ALIGN_CHECK_EN to exercise the fault path.
module tb_z16_fetch_unit;

    localparam int          DEPTH    = 4;
    localparam logic [15:0] RESET_PC = 16'h0000;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_redirect = 1'b0;
    logic [15:0] i_redirect_pc = 16'h0;
    logic        o_imem_req;
    logic [15:0] o_imem_addr;
    logic        i_imem_ack = 1'b0;
    logic [15:0] i_imem_data = 16'h0;
    logic        o_instr_valid;
    logic [15:0] o_instr;
    logic [15:0] o_instr_pc;
    logic        i_instr_ready = 1'b0;
    logic        o_fault;

    int checks = 0;
    int failures = 0;

    z16_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_imem_req    (o_imem_req),
        .o_imem_addr   (o_imem_addr),
        .i_imem_ack    (i_imem_ack),
        .i_imem_data   (i_imem_data),
        .o_instr_valid (o_instr_valid),
        .o_instr       (o_instr),
        .o_instr_pc    (o_instr_pc),
        .i_instr_ready (i_instr_ready),
        .o_fault       (o_fault)
    );

    always #5 i_clk = ~i_clk;

    // Reference model: a queue of {pc, instr}, the fetch PC and a fault flag.
    logic [31:0] q[$];
    logic [15:0] m_pc = RESET_PC;
    logic        m_fault = 1'b0;

    always @(posedge i_clk) begin
        logic ereq, evld;
        if (!i_rst_n) begin
            q.delete();
            m_pc = RESET_PC;
            m_fault = 1'b0;
        end else begin
            ereq = (q.size() < DEPTH) && !i_redirect && !m_fault;
            evld = (q.size() != 0) && !m_fault;
            if (evld && i_instr_ready) void'(q.pop_front());
            if (i_redirect) begin
                q.delete();
                m_pc = {i_redirect_pc[15:1], 1'b0};
`ifdef Z16_FETCH_ALIGN_CHECK_EN
                if (i_redirect_pc[0]) m_fault = 1'b1;
`endif
            end else if (ereq && i_imem_ack) begin
                q.push_back({m_pc, i_imem_data});
                m_pc = m_pc + 16'd2;
            end
        end
    end

    // Expected {req, addr, valid, instr, pc, fault} for the current cycle.
    function automatic logic [50:0] expv();
        logic ereq, evld;
        logic [31:0] h;
        ereq = i_rst_n && (q.size() < DEPTH) && !i_redirect && !m_fault;
        evld = i_rst_n && (q.size() != 0) && !m_fault;
        h = evld ? q[0] : 32'h0;
        return {ereq, m_pc, evld, h[15:0], h[31:16], m_fault};
    endfunction

    // Observed outputs; instruction fields only matter when the model expects valid.
    function automatic logic [50:0] obsv();
        logic evld;
        evld = i_rst_n && (q.size() != 0) && !m_fault;
        return {o_imem_req, o_imem_addr, o_instr_valid,
                evld ? o_instr : 16'h0, evld ? o_instr_pc : 16'h0, o_fault};
    endfunction

    // Advance one cycle and apply new inputs away from the clock edge.
    task automatic drive(input logic rst, input logic redir, input logic [15:0] rpc,
                         input logic ack, input logic rdy);
        @(posedge i_clk);
        #1;
        i_rst_n       = rst;
        i_redirect    = redir;
        i_redirect_pc = rpc;
        i_imem_ack    = ack;
        i_instr_ready = rdy;
        i_imem_data   = 16'($urandom);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
            checks++;
            if (o_imem_req !== 1'b0 || o_instr_valid !== 1'b0 || o_fault !== 1'b0) begin
                failures++;
                $display("FAIL reset_idle req=%b valid=%b fault=%b required 0 0 0",
                         o_imem_req, o_instr_valid, o_fault);
            end
            checks++;
            if (obsv() !== expv()) begin
                failures++;
                $display("FAIL reset_model got=%h exp=%h", obsv(), expv());
            end
        end
    endtask

    task automatic test_stream();
        drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 1'b0, 16'h0, 1'b1, 1'b1);
            checks++;
            if (o_imem_req !== 1'b1 || o_imem_addr !== 16'(2 * i)) begin
                failures++;
                $display("FAIL stream_addr cyc=%0d req=%b addr=%h required 1 %h",
                         i, o_imem_req, o_imem_addr, 16'(2 * i));
            end
            if (i > 0) begin
                checks++;
                if (o_instr_valid !== 1'b1 || o_instr_pc !== 16'(2 * (i - 1))) begin
                    failures++;
                    $display("FAIL stream_head cyc=%0d valid=%b pc=%h required 1 %h",
                             i, o_instr_valid, o_instr_pc, 16'(2 * (i - 1)));
                end
            end
            checks++;
            if (obsv() !== expv()) begin
                failures++;
                $display("FAIL stream_model cyc=%0d got=%h exp=%h", i, obsv(), expv());
            end
        end
    endtask

    task automatic test_full();
        drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
            checks++;
            if (obsv() !== expv()) begin
                failures++;
                $display("FAIL full_fill cyc=%0d got=%h exp=%h", i, obsv(), expv());
            end
        end
        checks++;
        if (o_imem_req !== 1'b0 || o_imem_addr !== 16'h0008 || o_instr_pc !== 16'h0000) begin
            failures++;
            $display("FAIL full_stall req=%b addr=%h head=%h required 0 0008 0000",
                     o_imem_req, o_imem_addr, o_instr_pc);
        end
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
            checks++;
            if (o_instr_valid !== (i < 4) || (i < 4 && o_instr_pc !== 16'(2 * i))) begin
                failures++;
                $display("FAIL full_drain cyc=%0d valid=%b pc=%h required %b %h",
                         i, o_instr_valid, o_instr_pc, (i < 4), 16'(2 * i));
            end
            checks++;
            if (obsv() !== expv()) begin
                failures++;
                $display("FAIL full_model cyc=%0d got=%h exp=%h", i, obsv(), expv());
            end
        end
    endtask

    task automatic test_redirect();
        drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 16'h0100, 1'b1, 1'b1);
        checks++;
        if (o_imem_req !== 1'b0 || o_instr_valid !== 1'b1 || o_instr_pc !== 16'h0000) begin
            failures++;
            $display("FAIL redir_cycle req=%b valid=%b pc=%h required 0 1 0000",
                     o_imem_req, o_instr_valid, o_instr_pc);
        end
        drive(1'b1, 1'b0, 16'h0, 1'b1, 1'b1);
        checks++;
        if (o_instr_valid !== 1'b0 || o_imem_req !== 1'b1 || o_imem_addr !== 16'h0100) begin
            failures++;
            $display("FAIL redir_r1 valid=%b req=%b addr=%h required 0 1 0100",
                     o_instr_valid, o_imem_req, o_imem_addr);
        end
        drive(1'b1, 1'b0, 16'h0, 1'b1, 1'b1);
        checks++;
        if (o_instr_valid !== 1'b1 || o_instr_pc !== 16'h0100) begin
            failures++;
            $display("FAIL redir_r2 valid=%b pc=%h required 1 0100", o_instr_valid, o_instr_pc);
        end
        checks++;
        if (obsv() !== expv()) begin
            failures++;
            $display("FAIL redir_model got=%h exp=%h", obsv(), expv());
        end
    endtask

    task automatic test_wrap();
        logic [15:0] want [3];
        want[0] = 16'hFFFC; want[1] = 16'hFFFE; want[2] = 16'h0000;
        drive(1'b1, 1'b1, 16'hFFFC, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 16'h0, 1'b1, 1'b1);
            checks++;
            if (o_imem_addr !== want[i] || o_imem_req !== 1'b1) begin
                failures++;
                $display("FAIL wrap_addr cyc=%0d addr=%h required %h", i, o_imem_addr, want[i]);
            end
        end
        checks++;
        if (obsv() !== expv()) begin
            failures++;
            $display("FAIL wrap_model got=%h exp=%h", obsv(), expv());
        end
    endtask

    task automatic test_midreset();
        for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
        checks++;
        if (o_imem_req !== 1'b0 || o_instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL midrst_hold req=%b valid=%b required 0 0", o_imem_req, o_instr_valid);
        end
        drive(1'b1, 1'b0, 16'h0, 1'b1, 1'b1);
        checks++;
        if (o_instr_valid !== 1'b0 || o_imem_req !== 1'b1 || o_imem_addr !== RESET_PC) begin
            failures++;
            $display("FAIL midrst_after valid=%b req=%b addr=%h required 0 1 %h",
                     o_instr_valid, o_imem_req, o_imem_addr, RESET_PC);
        end
    endtask

    task automatic test_misaligned();
        drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 16'h0101, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 16'h0, 1'b1, 1'b1);
`ifdef Z16_FETCH_ALIGN_CHECK_EN
            checks++;
            if (o_fault !== 1'b1 || o_imem_req !== 1'b0 || o_instr_valid !== 1'b0) begin
                failures++;
                $display("FAIL misalign_fault cyc=%0d fault=%b req=%b valid=%b required 1 0 0",
                         i, o_fault, o_imem_req, o_instr_valid);
            end
`else
            checks++;
            if (o_fault !== 1'b0 || o_imem_req !== 1'b1 || o_imem_addr !== 16'(16'h0100 + 2 * i)) begin
                failures++;
                $display("FAIL misalign_clear cyc=%0d fault=%b req=%b addr=%h required 0 1 %h",
                         i, o_fault, o_imem_req, o_imem_addr, 16'(16'h0100 + 2 * i));
            end
`endif
            checks++;
            if (obsv() !== expv()) begin
                failures++;
                $display("FAIL misalign_model cyc=%0d got=%h exp=%h", i, obsv(), expv());
            end
        end
        drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        checks++;
        if (o_fault !== 1'b0) begin
            failures++;
            $display("FAIL misalign_reset fault=%b required 0", o_fault);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            logic rst, redir;
            logic [15:0] rpc;
            rst   = ($urandom_range(99) >= 2);
            redir = ($urandom_range(99) < 8);
            rpc   = 16'($urandom);
            if ($urandom_range(99) >= 5) rpc[0] = 1'b0;
            drive(rst, redir, rpc, 1'($urandom_range(3) != 0), 1'($urandom_range(2) != 0));
            checks++;
            if (obsv() !== expv()) begin
                failures++;
                $display("FAIL random cyc=%0d got=%h exp=%h", i, obsv(), expv());
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_full();
        test_redirect();
        test_wrap();
        test_midreset();
        test_misaligned();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
